// File: rtl/instr_sequencer.sv
// instr_sequencer: issuing side of the run/instruction/done handshake.
// Holds a DEPTH x 16-bit program store loaded while idle. Once started it
// presents one instruction at a time with run high, waits for done, spends
// one cycle with run low, then advances. A watchdog flags a control unit
// that never answers. All outputs are registered.
// Optional build macro: SEQ_SINGLE_STEP_EN adds a 'step' input and a PAUSE
// state, so each instruction after the first waits for a step pulse.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    input  logic          done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [15:0]   instruction,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic          error
);

    localparam int           WW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_FIN,
        S_ERR
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    logic [15:0]   r_mem [DEPTH];

    state_t        r_state,  w_state;
    logic [AW-1:0] r_pc,     w_pc;
    logic [15:0]   r_instr,  w_instr;
    logic          r_run,    w_run;
    logic [WW-1:0] r_wdog,   w_wdog;
    logic [AW:0]   r_len,    w_len;
    logic          r_busy,   r_fin,   r_err;

    logic [AW-1:0] w_pc_inc;
    logic [AW:0]   w_pc_inc_ext;
    logic [AW:0]   w_len_clamp;
    logic          w_go;

    assign w_pc_inc     = r_pc + AW'(1);
    assign w_pc_inc_ext = {1'b0, r_pc} + (AW + 1)'(1);
    assign w_len_clamp  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign w_go         = start && (prog_len != '0);

    assign instruction = r_instr;
    assign run         = r_run;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign finished    = r_fin;
    assign error       = r_err;

    // Program store: writable only while idle, no reset on contents.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == S_IDLE)
            r_mem[wr_addr] <= wr_data;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_run   <= 1'b0;
            r_wdog  <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_instr <= w_instr;
            r_run   <= w_run;
            r_wdog  <= w_wdog;
            r_len   <= w_len;
            r_busy  <= (w_state == S_ISSUE) || (w_state == S_GAP);
            r_fin   <= (w_state == S_FIN);
            r_err   <= (w_state == S_ERR);
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_instr = r_instr;
        w_run   = r_run;
        w_wdog  = r_wdog;
        w_len   = r_len;
        if (abort) begin
            w_state = S_IDLE;
            w_run   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_go) begin
                        w_state = S_ISSUE;
                        w_pc    = '0;
                        w_instr = r_mem[0];
                        w_run   = 1'b1;
                        w_wdog  = '0;
                        w_len   = w_len_clamp;
                    end
                end
                S_ISSUE: begin
                    w_wdog = r_wdog + WW'(1);
                    if (done) begin
                        w_state = S_GAP;
                        w_run   = 1'b0;
                    end else if (r_wdog == WD_LAST) begin
                        w_state = S_ERR;
                        w_run   = 1'b0;
                    end
                end
                S_GAP: begin
                    if (w_pc_inc_ext == r_len) begin
                        w_state = S_FIN;
                    end else begin
                        w_pc    = w_pc_inc;
                        w_instr = r_mem[w_pc_inc];
                        w_wdog  = '0;
`ifdef SEQ_SINGLE_STEP_EN
                        w_state = S_PAUSE;
                        w_run   = 1'b0;
`else
                        w_state = S_ISSUE;
                        w_run   = 1'b1;
`endif
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        w_state = S_ISSUE;
                        w_run   = 1'b1;
                    end
                end
`endif
                S_ERR: begin
                    w_run = 1'b0;
                end
                default: begin
                    w_state = S_IDLE;
                    w_run   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program load, 3-instruction run with a
// 4-cycle control unit, watchdog, abort priority, ignored writes, zero-length
// start, asynchronous reset mid-run, and single-step mode when
// SEQ_SINGLE_STEP_EN is defined.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic          done;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step;
`endif
    logic [15:0]   instruction;
    logic          run;
    logic [AW-1:0] pc;
    logic          busy;
    logic          finished;
    logic          error;

    int n_vec  = 0;
    int n_miss = 0;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .done        (done),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .instruction (instruction),
        .run         (run),
        .pc          (pc),
        .busy        (busy),
        .finished    (finished),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; leaves us at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go(input int len);
        prog_len = (AW + 1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Expected outputs of cycle c of the 3-instruction program (cycle 1 is
    // the first cycle after the start edge); done is driven on cycles 4/9/14.
    task automatic exp3(input int c);
        logic        e_run;
        logic [3:0]  e_pc;
        logic [15:0] e_ins;
        e_run = !(c == 5 || c == 10 || c >= 15);
        if (c <= 5) begin
            e_pc = 4'd0; e_ins = 16'h2001;
        end else if (c <= 10) begin
            e_pc = 4'd1; e_ins = 16'h4002;
        end else begin
            e_pc = 4'd2; e_ins = 16'h6003;
        end
        check($sformatf("run@c%0d", c),   32'(run),         32'(e_run));
        check($sformatf("pc@c%0d", c),    32'(pc),          32'(e_pc));
        check($sformatf("instr@c%0d", c), 32'(instruction), 32'(e_ins));
        check($sformatf("fin@c%0d", c),   32'(finished),    32'(c >= 16));
        check($sformatf("busy@c%0d", c),  32'(busy),        32'(c <= 15));
        check($sformatf("err@c%0d", c),   32'(error),       32'(0));
        done = (c == 4 || c == 9 || c == 14);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0; done = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        check("rst_instr", 32'(instruction), 32'(0));
        check("rst_run",   32'(run),         32'(0));
        check("rst_pc",    32'(pc),          32'(0));
        check("rst_busy",  32'(busy),        32'(0));
        check("rst_fin",   32'(finished),    32'(0));
        check("rst_err",   32'(error),       32'(0));
        reset = 1'b1;
        tick();

        // Load program.
        wr_en = 1'b1;
        wr_addr = 4'd0; wr_data = 16'h2001; tick();
        wr_addr = 4'd1; wr_data = 16'h4002; tick();
        wr_addr = 4'd2; wr_data = 16'h6003; tick();
        wr_en = 1'b0;

`ifndef SEQ_SINGLE_STEP_EN
        // Full 3-instruction run.
        go(3);
        for (int c = 1; c <= 18; c++) begin
            exp3(c);
            tick();
        end
        done = 1'b0;
`endif

        // Watchdog: no done for 8 run cycles (restart from FIN in default build).
        go(3);
        check("wd_fin_clr", 32'(finished), 32'(0));
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("wd_run@%0d", c), 32'(run), 32'(1));
            check($sformatf("wd_err@%0d", c), 32'(error), 32'(0));
            tick();
        end
        check("wd_run_off", 32'(run),   32'(0));
        check("wd_err_on",  32'(error), 32'(1));
        check("wd_busy",    32'(busy),  32'(0));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wd_err_held", 32'(error), 32'(1));
        check("wd_run_held", 32'(run),   32'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd_abort_err",  32'(error),    32'(0));
        check("wd_abort_run",  32'(run),      32'(0));
        check("wd_abort_busy", 32'(busy),     32'(0));
        check("wd_abort_pc",   32'(pc),       32'(0));

        // done and abort together in ISSUE: abort wins.
        go(3);
        check("da_run1", 32'(run), 32'(1));
        done = 1'b1; abort = 1'b1;
        tick();
        done = 1'b0; abort = 1'b0;
        check("da_run",  32'(run),      32'(0));
        check("da_fin",  32'(finished), 32'(0));
        check("da_busy", 32'(busy),     32'(0));
        check("da_err",  32'(error),    32'(0));
        tick();
        check("da_idle_run",  32'(run),  32'(0));
        check("da_idle_busy", 32'(busy), 32'(0));

        // Zero-length start is ignored.
        go(0);
        check("len0_run",  32'(run),  32'(0));
        check("len0_busy", 32'(busy), 32'(0));
        tick();
        check("len0_run2", 32'(run),  32'(0));

`ifndef SEQ_SINGLE_STEP_EN
        // done on the timeout cycle beats the watchdog; abort keeps pc.
        go(3);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("tw_run@%0d", c), 32'(run), 32'(1));
            done = (c == 8);
            tick();
        end
        done = 1'b0;
        check("tw_err",  32'(error), 32'(0));
        check("tw_run",  32'(run),   32'(0));
        check("tw_busy", 32'(busy),  32'(1));
        tick();
        check("tw_next_run", 32'(run),         32'(1));
        check("tw_next_pc",  32'(pc),          32'(1));
        check("tw_next_ins", 32'(instruction), 32'(16'h4002));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("tw_abort_run", 32'(run),  32'(0));
        check("tw_abort_pc",  32'(pc),   32'(1));
        check("tw_abort_bsy", 32'(busy), 32'(0));

        // Write during ISSUE is ignored; mem[1] must still read 4002.
        go(3);
        for (int c = 1; c <= 7; c++) begin
            exp3(c);
            wr_en = (c == 1); wr_addr = 4'd1; wr_data = 16'hFFFF;
            tick();
        end
        wr_en = 1'b0; done = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wr_abort_run", 32'(run), 32'(0));

        // Asynchronous reset during the second instruction.
        go(3);
        for (int c = 1; c <= 7; c++) begin
            exp3(c);
            if (c < 7) tick();
        end
        done = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("arst_run",   32'(run),         32'(0));
        check("arst_pc",    32'(pc),          32'(0));
        check("arst_instr", 32'(instruction), 32'(0));
        check("arst_busy",  32'(busy),        32'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("arst_idle_run",  32'(run),  32'(0));
        check("arst_idle_busy", 32'(busy), 32'(0));
        go(3);
        for (int c = 1; c <= 17; c++) begin
            exp3(c);
            tick();
        end
        done = 1'b0;
`else
        // Single step: pause after the first instruction until step.
        go(2);
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("ss_run@%0d", c), 32'(run), 32'(c <= 4));
            done = (c == 4);
            tick();
        end
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ss_pause_run@%0d", k), 32'(run), 32'(0));
            check($sformatf("ss_pause_pc@%0d", k),  32'(pc),  32'(1));
            check($sformatf("ss_pause_ins@%0d", k), 32'(instruction), 32'(16'h4002));
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss_step_run", 32'(run),         32'(1));
        check("ss_step_ins", 32'(instruction), 32'(16'h4002));
        check("ss_step_pc",  32'(pc),          32'(1));
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ss2_run@%0d", k), 32'(run), 32'(1));
            done = (k == 4);
            tick();
        end
        done = 1'b0;
        check("ss_gap_run", 32'(run),      32'(0));
        check("ss_gap_fin", 32'(finished), 32'(0));
        tick();
        check("ss_fin",     32'(finished), 32'(1));
        check("ss_fin_run", 32'(run),      32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
